// File: rtl/mem_stall_controller.sv
// mem_stall_controller
//   Data-memory stall controller for an in-order pipeline. A load or store in
//   the MEM stage freezes the whole pipeline while a multi-cycle memory access
//   runs (IDLE -> ACCESS -> DONE). Outside a freeze, the hazard unit's
//   load-use stall and taken-branch flush requests are turned into the
//   pipeline register write enables.
//
//   Ports
//     clk_i            clock, rising edge
//     rst_i            asynchronous active-high reset
//     mem_read_i       MEM-stage instruction is a load
//     mem_write_i      MEM-stage instruction is a store
//     mem_ready_i      memory has completed the request, mem_rdata_i valid
//     mem_rdata_i      memory read data
//     hazard_stall_i   load-use stall request
//     branch_flush_i   taken-branch flush request
//     mem_req_o        request to data memory (from state only)
//     pc_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o
//                      pipeline register write enables
//     stall_o          zero ID/EX control signals (bubble)
//     flush_o          clear IF/ID
//     rdata_q_o        captured load data for MEM/WB
//     bus_err_o        sticky access-timeout flag
//     stall_cycles_o   saturating count of frozen/stalled cycles
module mem_stall_controller #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              hazard_stall_i,
  input  logic              branch_flush_i,
  output logic              mem_req_o,
  output logic              pc_write_o,
  output logic              IF_ID_write_o,
  output logic              ID_EX_write_o,
  output logic              EX_MEM_write_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] rdata_q_o,
  output logic              bus_err_o,
  output logic [15:0]       stall_cycles_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Last wait count value before the access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;

  logic              mem_op_s;
  logic              freeze_s;

  assign mem_op_s = mem_read_i | mem_write_i;

  // Freeze starts combinationally in the IDLE cycle that sees the memory op,
  // so the instruction is held in MEM before the request is even issued.
  assign freeze_s = ((state_q == S_IDLE) && mem_op_s) || (state_q == S_ACCESS);

  // Next-state, wait counter, load data capture and timeout error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          state_d    = S_ACCESS;
          wait_cnt_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem_ready_i) begin
          state_d = S_DONE;
          if (mem_read_i) begin
            rdata_d = mem_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Access never completed: flag it and hand a zero word onward.
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pipeline control: freeze dominates, then load-use stall, then flush.
  always_comb begin
    pc_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_write_o  = 1'b1;
    EX_MEM_write_o = 1'b1;
    stall_o        = 1'b0;
    flush_o        = 1'b0;
    if (freeze_s) begin
      pc_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_write_o  = 1'b0;
      EX_MEM_write_o = 1'b0;
    end else if (hazard_stall_i) begin
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      stall_o       = 1'b1;
    end else if (branch_flush_i) begin
      flush_o = 1'b1;
    end else begin
      flush_o = 1'b0;
    end
  end

  // Saturating count of cycles the pipeline did not advance normally.
  always_comb begin
    if ((freeze_s || stall_o) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= 8'd0;
      rdata_q        <= '0;
      bus_err_q      <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      rdata_q        <= rdata_d;
      bus_err_q      <= bus_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // mem_req follows state only, so reset drops it in the same cycle.
  assign mem_req_o      = (state_q == S_ACCESS);
  assign rdata_q_o      = rdata_q;
  assign bus_err_o      = bus_err_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_mem_stall_controller.sv
module tb_mem_stall_controller;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write, mem_ready;
  logic [31:0] mem_rdata;
  logic        hazard_stall, branch_flush;
  logic        mem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        stall, flush, bus_err;
  logic [31:0] rdata_q;
  logic [15:0] stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stall_controller #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .mem_ready_i   (mem_ready),
    .mem_rdata_i   (mem_rdata),
    .hazard_stall_i(hazard_stall),
    .branch_flush_i(branch_flush),
    .mem_req_o     (mem_req),
    .pc_write_o    (pc_write),
    .IF_ID_write_o (if_id_write),
    .ID_EX_write_o (id_ex_write),
    .EX_MEM_write_o(ex_mem_write),
    .stall_o       (stall),
    .flush_o       (flush),
    .rdata_q_o     (rdata_q),
    .bus_err_o     (bus_err),
    .stall_cycles_o(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // Expected outputs for one cycle; ctl = {mem_req, pc, ifid, idex, exmem, stall, flush}
  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 IDLE, 1 ACCESS, 2 DONE
  int          ms;
  int          mwait;
  logic [31:0] mrdata;
  logic        merr;
  logic [15:0] mcyc;

  task automatic model_reset();
    ms = 0; mwait = 0; mrdata = 32'd0; merr = 1'b0; mcyc = 16'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic m_freeze();
    return ((ms == 0) && (mem_read || mem_write)) || (ms == 1);
  endfunction

  // Push the spec-derived expectation for the inputs currently driven.
  task automatic push_expect(input string tag);
    exp_t e;
    e.tag    = tag;
    e.ctl[6] = (ms == 1);
    if (m_freeze())        e.ctl[5:0] = 6'b000000;
    else if (hazard_stall) e.ctl[5:0] = 6'b001110;
    else if (branch_flush) e.ctl[5:0] = 6'b111101;
    else                   e.ctl[5:0] = 6'b111100;
    e.rdata = mrdata;
    e.err   = merr;
    e.cyc   = mcyc;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/ctl"}, {25'd0, mem_req, pc_write, if_id_write, id_ex_write,
                            ex_mem_write, stall, flush}, {25'd0, e.ctl});
      chk({e.tag, "/rdata"}, rdata_q, e.rdata);
      chk({e.tag, "/bus_err"}, {31'd0, bus_err}, {31'd0, e.err});
      chk({e.tag, "/stall_cycles"}, {16'd0, stall_cycles}, {16'd0, e.cyc});
    end
  endtask

  // Advance the model across one rising edge with the current inputs.
  task automatic model_step();
    logic fr;
    logic st;
    fr = m_freeze();
    st = !fr && hazard_stall;
    if ((fr || st) && mcyc != 16'hFFFF) mcyc = mcyc + 16'd1;
    case (ms)
      0: if (mem_read || mem_write) begin ms = 1; mwait = 0; end
      1: begin
        if (mem_ready) begin
          ms = 2;
          if (mem_read) mrdata = mem_rdata;
        end else if (mwait == 15) begin
          ms = 2; merr = 1'b1; mrdata = 32'd0;
        end else begin
          mwait = mwait + 1;
        end
      end
      default: ms = 0;
    endcase
  endtask

  // One clock cycle: drive at negedge, compare mid-low-phase, clock through.
  task automatic step(input string tag, input logic rd, input logic wr, input logic rdy,
                      input logic [31:0] rdat, input logic hs, input logic bf);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_ready = rdy; mem_rdata = rdat;
    hazard_stall = hs; branch_flush = bf;
    push_expect(tag);
    #1;
    pop_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    hazard_stall = 1'b0; branch_flush = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk); #1;
    chk("rst/mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst/rdata", rdata_q, 32'd0);
    chk("rst/bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst/stall_cycles", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step("idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("idle_ready_ignored", 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    chk("idle_ready/rdata", rdata_q, 32'd0);

    // Load, ready in third ACCESS cycle
    step("ld_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("ld_acc1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("ld_acc2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("ld_acc3", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ld_done/rdata", rdata_q, 32'hDEADBEEF);
    chk("ld_done/stall_cycles", {16'd0, stall_cycles}, 32'd4);
    chk("ld_done/mem_req", {31'd0, mem_req}, 32'd0);
    step("ld_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Store, ready in first ACCESS cycle
    step("st_idle", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("st_acc/mem_req", {31'd0, mem_req}, 32'd1);
    step("st_acc", 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    chk("st_done/mem_req", {31'd0, mem_req}, 32'd0);
    chk("st_done/ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
    chk("st_done/rdata", rdata_q, 32'hDEADBEEF);
    step("st_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Hazard priority without and with a memory op
    step("hz_only", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step("bf_only", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step("hz_mem_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("hz_mem_acc/stall", {31'd0, stall}, 32'd0);
    chk("hz_mem_acc/pc_write", {31'd0, pc_write}, 32'd0);
    step("hz_mem_acc", 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
    step("hz_mem_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Back-to-back loads
    step("b2b_idle1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("b2b_acc1", 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0);
    step("b2b_done1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("b2b_idle2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("b2b_acc2/mem_req", {31'd0, mem_req}, 32'd1);
    step("b2b_acc2", 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0);
    chk("b2b_done2/rdata", rdata_q, 32'h22222222);
    step("b2b_done2", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("b2b_idle3", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Timeout: memory never ready
    step("to_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("to_acc%0d", i), 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    end
    chk("to_done/bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_done/rdata", rdata_q, 32'd0);
    chk("to_done/mem_req", {31'd0, mem_req}, 32'd0);
    step("to_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("to_after%0d", i), 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    end
    chk("to_sticky/bus_err", {31'd0, bus_err}, 32'd1);

    // Reset pulse in the middle of an access
    step("rst_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_pre/mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid/mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid/bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mid/stall_cycles", {16'd0, stall_cycles}, 32'd0);
    chk("rst_mid/rdata", rdata_q, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;

    // Normal operation after reset
    step("post_idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("post_ld_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("post_ld_acc", 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    step("post_ld_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("post/rdata", rdata_q, 32'hCAFEF00D);
    chk("post/stall_cycles", {16'd0, stall_cycles}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
